// File: rtl/compound_accumulator.sv
// compound_accumulator: running signed sum of 32-bit samples. Each accepted
// sample pushes one {x, y} message into a small FIFO, where x is the new sum
// and y flags signed overflow. The FIFO is drained through a blocking
// output port.
// Optional feature macro: COMPOUND_ACCUMULATOR_SAT_EN. When it is defined,
// the sum saturates on overflow; otherwise it wraps modulo 2^32.
// c_out packing: c_out[32:1] = x (signed), c_out[0] = y.
module compound_accumulator #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] val_in,
  input  logic        val_in_sync,
  output logic        val_in_notify,
  output logic [32:0] c_out,
  input  logic        c_out_sync,
  output logic        c_out_notify,
  input  logic        clear
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [32:0]   last_q, last_d;
  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   mem_d [DEPTH];

  logic        accept;
  logic        deliver;
  logic [31:0] base;
  logic [32:0] sum;
  logic        ovf;
  logic [31:0] new_x;

  // Handshake flags depend only on the registered count, so no input
  // can reach an output combinationally.
  always_comb begin
    val_in_notify = (count_q != FULL_COUNT);
    c_out_notify  = (count_q != '0);
    c_out         = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  end

  // Sum against zero when clear arrives with a sample; overflow is detected
  // by comparing the two top bits of the sign-extended 33-bit sum.
  always_comb begin
    accept  = val_in_sync && val_in_notify;
    deliver = c_out_sync && c_out_notify;
    base    = clear ? 32'd0 : acc_q;
    sum     = {base[31], base} + {val_in[31], val_in};
    ovf     = (sum[32] != sum[31]);
`ifdef COMPOUND_ACCUMULATOR_SAT_EN
    if (ovf) begin
      new_x = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      new_x = sum[31:0];
    end
`else
    new_x = sum[31:0];
`endif
  end

  // Next-state for accumulator, FIFO storage, pointers, count and the
  // last-delivered message that c_out shows while the FIFO is empty.
  always_comb begin
    acc_d    = acc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    mem_d    = mem_q;
    if (accept) begin
      acc_d           = new_x;
      mem_d[wr_ptr_q] = {new_x, ovf};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else if (clear) begin
      acc_d = 32'd0;
    end
    if (deliver) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (accept && !deliver) begin
      count_d = count_q + CW'(1);
    end else if (deliver && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  // State registers with asynchronous reset discarding all contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      acc_q    <= acc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_compound_accumulator.sv
// tb_compound_accumulator: randomized and directed checks of
// compound_accumulator against a queue-based behavioural model.
module tb_compound_accumulator;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] val_in = '0;
  logic        val_in_sync = 1'b0;
  logic        val_in_notify;
  logic [32:0] c_out;
  logic        c_out_sync = 1'b0;
  logic        c_out_notify;
  logic        clear = 1'b0;

  int total = 0;
  int bad = 0;

  // Behavioural model: message queue, running sum and last delivered message.
  logic [32:0] exp_q[$];
  logic [32:0] last_m = '0;
  longint      acc_m = 0;

  compound_accumulator #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .val_in(val_in),
    .val_in_sync(val_in_sync),
    .val_in_notify(val_in_notify),
    .c_out(c_out),
    .c_out_sync(c_out_sync),
    .c_out_notify(c_out_notify),
    .clear(clear)
  );

  // Free-running clock: posedges at 5, 15, 25, ...; stimulus and sampling at negedges.
  always #5 clk = ~clk;

  function automatic logic exp_vin();
    return exp_q.size() != DEPTH;
  endfunction

  function automatic logic exp_cnot();
    return exp_q.size() != 0;
  endfunction

  function automatic logic [32:0] exp_cout();
    return (exp_q.size() != 0) ? exp_q[0] : last_m;
  endfunction

  // Expected message for sample v, computed with wide integer arithmetic.
  function automatic logic [32:0] model_msg(input logic [31:0] v, input logic clr);
    longint s;
    logic [63:0] s_bits;
    logic ovf;
    logic [31:0] x;
    s = (clr ? 64'sd0 : acc_m) + longint'($signed(v));
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    s_bits = s;
    x = s_bits[31:0];
`ifdef COMPOUND_ACCUMULATOR_SAT_EN
    if (ovf) x = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {x, ovf};
  endfunction

  function automatic logic [32:0] mk(input logic [31:0] x, input logic y);
    return {x, y};
  endfunction

  // Drive one cycle of inputs at a negedge, advance the model, wait for the next negedge.
  task automatic step(input logic vs, input logic [31:0] v, input logic cs, input logic clr);
    logic do_acc, do_del;
    logic [32:0] m;
    val_in_sync = vs;
    val_in      = v;
    c_out_sync  = cs;
    clear       = clr;
    do_acc = vs && (exp_q.size() != DEPTH);
    do_del = cs && (exp_q.size() != 0);
    if (do_del) last_m = exp_q.pop_front();
    if (do_acc) begin
      m = model_msg(v, clr);
      exp_q.push_back(m);
      acc_m = longint'($signed(m[32:1]));
    end else if (clr) begin
      acc_m = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    val_in_sync = 1'b0;
    c_out_sync  = 1'b0;
    clear       = 1'b0;
    val_in      = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 2 && exp_q.size() != 0; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0);
      total++;
      if (c_out !== exp_cout()) begin
        bad++;
        $display("[TB] FAIL drain_c_out got=%h want=%h", c_out, exp_cout());
      end
    end
    total++;
    if (exp_q.size() != 0 || c_out_notify !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_timeout c_out_notify got=%0b want=0", c_out_notify);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (val_in_notify !== 1'b1 || c_out_notify !== 1'b0 || c_out !== 33'd0) begin
      bad++;
      $display("[TB] FAIL reset_init got vn=%0b cn=%0b c=%h want 1 0 0", val_in_notify, c_out_notify, c_out);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom_range(1, 1000), 1'b0, 1'b0);
    end
    total++;
    if (val_in_notify !== 1'b1 || c_out_notify !== 1'b1 || c_out !== exp_cout()) begin
      bad++;
      $display("[TB] FAIL reset_prefill got vn=%0b cn=%0b c=%h want 1 1 %h", val_in_notify, c_out_notify, c_out, exp_cout());
    end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    total++;
    if (val_in_notify !== 1'b1 || c_out_notify !== 1'b0 || c_out !== 33'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid got vn=%0b cn=%0b c=%h want 1 0 0", val_in_notify, c_out_notify, c_out);
    end
    exp_q.delete();
    acc_m = 0;
    last_m = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    step(1'b1, 32'd42, 1'b1, 1'b0);
    total++;
    if (c_out_notify !== 1'b1 || c_out !== mk(32'd42, 1'b0)) begin
      bad++;
      $display("[TB] FAIL reset_restart got cn=%0b c=%h want 1 %h", c_out_notify, c_out, mk(32'd42, 1'b0));
    end
    drain();
  endtask

  task automatic test_basic_sum();
    logic [31:0] samples [3];
    logic [31:0] sums [3];
    samples = '{32'd5, 32'hFFFF_FFFE, 32'd10};
    sums    = '{32'd5, 32'd3, 32'd13};
    step(1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, samples[i], 1'b1, 1'b0);
      total++;
      if (c_out_notify !== 1'b1 || c_out !== mk(sums[i], 1'b0)) begin
        bad++;
        $display("[TB] FAIL basic_sum_%0d got cn=%0b c=%h want 1 %h", i, c_out_notify, c_out, mk(sums[i], 1'b0));
      end
    end
    drain();
    total++;
    if (c_out !== mk(32'd13, 1'b0)) begin
      bad++;
      $display("[TB] FAIL basic_hold_last got=%h want=%h", c_out, mk(32'd13, 1'b0));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] samples [5];
    int idx;
    int delivered;
    for (int i = 0; i < 5; i++) samples[i] = $urandom_range(0, 5000);
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      if (exp_vin()) begin
        step(1'b1, samples[idx], 1'b0, 1'b0);
        idx++;
      end else begin
        step(1'b1, samples[idx], 1'b0, 1'b0);
      end
      total++;
      if (val_in_notify !== exp_vin() || c_out_notify !== exp_cnot() || c_out !== exp_cout()) begin
        bad++;
        $display("[TB] FAIL bp_fill_%0d got vn=%0b cn=%0b c=%h want %0b %0b %h", i, val_in_notify, c_out_notify, c_out, exp_vin(), exp_cnot(), exp_cout());
      end
    end
    total++;
    if (val_in_notify !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_full got vn=%0b want=0", val_in_notify);
    end
    delivered = 0;
    for (int i = 0; i < 20 && (idx < 5 || exp_q.size() != 0); i++) begin
      if (exp_cnot()) delivered++;
      if (idx < 5 && exp_vin()) begin
        step(1'b1, samples[idx], 1'b1, 1'b0);
        idx++;
      end else begin
        step(idx < 5, (idx < 5) ? samples[idx] : 32'd0, 1'b1, 1'b0);
      end
      total++;
      if (val_in_notify !== exp_vin() || c_out_notify !== exp_cnot() || c_out !== exp_cout()) begin
        bad++;
        $display("[TB] FAIL bp_drain_%0d got vn=%0b cn=%0b c=%h want %0b %0b %h", i, val_in_notify, c_out_notify, c_out, exp_vin(), exp_cnot(), exp_cout());
      end
    end
    total++;
    if (delivered != 5) begin
      bad++;
      $display("[TB] FAIL bp_delivered got=%0d want=5", delivered);
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    logic [32:0] want_pos, want_neg;
`ifdef COMPOUND_ACCUMULATOR_SAT_EN
    want_pos = mk(32'h7FFF_FFFF, 1'b1);
    want_neg = mk(32'h8000_0000, 1'b1);
`else
    want_pos = mk(32'h8000_0000, 1'b1);
    want_neg = mk(32'h7FFF_FFFF, 1'b1);
`endif
    drain();
    step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    step(1'b1, 32'd1, 1'b1, 1'b0);
    total++;
    if (c_out !== want_pos || c_out !== exp_cout()) begin
      bad++;
      $display("[TB] FAIL ovf_pos got=%h want=%h", c_out, want_pos);
    end
    step(1'b1, 32'h8000_0000, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    total++;
    if (c_out !== want_neg || c_out !== exp_cout()) begin
      bad++;
      $display("[TB] FAIL ovf_neg got=%h want=%h", c_out, want_neg);
    end
    drain();
  endtask

  task automatic test_clear_accept();
    step(1'b1, 32'd100, 1'b1, 1'b1);
    step(1'b1, 32'd7, 1'b1, 1'b1);
    total++;
    if (c_out !== mk(32'd7, 1'b0)) begin
      bad++;
      $display("[TB] FAIL clear_accept got=%h want=%h", c_out, mk(32'd7, 1'b0));
    end
    step(1'b1, 32'd1, 1'b1, 1'b0);
    total++;
    if (c_out !== mk(32'd8, 1'b0)) begin
      bad++;
      $display("[TB] FAIL clear_next got=%h want=%h", c_out, mk(32'd8, 1'b0));
    end
    drain();
  endtask

  task automatic test_back_to_back();
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'b1, 1'b0);
      total++;
      if (val_in_notify !== 1'b1 || c_out_notify !== 1'b1 || c_out !== exp_cout() || exp_q.size() != 2) begin
        bad++;
        $display("[TB] FAIL b2b_%0d got vn=%0b cn=%0b c=%h want 1 1 %h", i, val_in_notify, c_out_notify, c_out, exp_cout());
      end
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 50);
        2: v = 32'h7FFF_FFF0 + $urandom_range(0, 31);
        default: v = 32'h8000_0000 + $urandom_range(0, 31);
      endcase
      step($urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      total++;
      if (val_in_notify !== exp_vin() || c_out_notify !== exp_cnot() || c_out !== exp_cout()) begin
        bad++;
        $display("[TB] FAIL random_%0d got vn=%0b cn=%0b c=%h want %0b %0b %h", i, val_in_notify, c_out_notify, c_out, exp_vin(), exp_cnot(), exp_cout());
      end
    end
    idle_inputs();
    drain();
  endtask

  // Test sequence followed by the single summary line.
  initial begin
    test_reset();
    test_basic_sum();
    test_backpressure();
    test_overflow();
    test_clear_accept();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
